tuner_sweep_ctrl: RTL and testbench

TUNER_SWEEP_CTRL -- requirements
Module: tuner_sweep_ctrl

---
 rtl/wdm_pkg.sv | 22 ++
 rtl/tuner_sweep_best_tracker.sv | 47 ++++
 rtl/tuner_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_tuner_sweep_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdm_pkg.sv
// Shared WDM tuner types: sweep mode, DAC code and the sweep controller
// state encoding used by tuner_sweep_ctrl.
package wdm_pkg;

    typedef enum logic {
        TUNER_MIN_THRU = 1'b0,
        TUNER_MAX_DROP = 1'b1
    } tuner_mode_e;

    typedef logic [7:0] tuner_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_SETTLE,
        ST_REQ,
        ST_WAIT,
        ST_UPDATE,
        ST_DONE
    } tuner_sweep_state_e;

endpackage

// File: rtl/tuner_sweep_best_tracker.sv
// Tracks the best (lowest or highest) power sample seen and its DAC code.
// Ports: i_mode, i_sample, i_code, i_update, i_clear ->
// o_best_code, o_best_pwr, o_nxt_code (best code including this update).
module tuner_sweep_best_tracker #(
    parameter int DAC_WIDTH = 8,
    parameter int ADC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_mode,
    input  logic [ADC_WIDTH-1:0] i_sample,
    input  logic [DAC_WIDTH-1:0] i_code,
    input  logic                 i_update,
    input  logic                 i_clear,
    output logic [DAC_WIDTH-1:0] o_best_code,
    output logic [DAC_WIDTH-1:0] o_nxt_code,
    output logic [ADC_WIDTH-1:0] o_best_pwr
);

    logic [DAC_WIDTH-1:0] r_best_code;
    logic [ADC_WIDTH-1:0] r_best_pwr;
    logic                 w_better;

    // Strict compare: ties keep the earlier code.
    always_comb begin
        w_better   = i_mode ? (i_sample > r_best_pwr)
                            : (i_sample < r_best_pwr);
        o_nxt_code = (i_update && w_better) ? i_code : r_best_code;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_best_code <= '0;
            r_best_pwr  <= '0;
        end else if (i_clear) begin
            r_best_code <= i_code;
            r_best_pwr  <= i_mode ? '0 : '1;
        end else if (i_update && w_better) begin
            r_best_code <= i_code;
            r_best_pwr  <= i_sample;
        end
    end

    assign o_best_code = r_best_code;
    assign o_best_pwr  = r_best_pwr;

endmodule

// File: rtl/tuner_sweep_ctrl.sv
// Sweeps the tuning DAC over a code range, measures power at each point
// and parks the DAC on the best code.
// Ports: sweep control (start/abort/mode/range), DAC code out, power
// read request and detect result handshakes, busy/done and best result.
module tuner_sweep_ctrl
    import wdm_pkg::*;
#(
    parameter int DAC_WIDTH    = 8,
    parameter int ADC_WIDTH    = 8,
    parameter int SettleCycles = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sweep_start,
    input  logic                 i_sweep_abort,
    input  logic                 i_sweep_mode,
    input  logic [DAC_WIDTH-1:0] i_code_start,
    input  logic [DAC_WIDTH-1:0] i_code_end,
    input  logic [DAC_WIDTH-1:0] i_code_step,
    output logic [DAC_WIDTH-1:0] o_dac_tune,
    output logic                 o_pwr_read_val,
    input  logic                 i_pwr_read_rdy,
    input  logic                 i_pwr_detect_val,
    output logic                 o_pwr_detect_rdy,
    input  logic [ADC_WIDTH-1:0] i_pwr_detect_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DAC_WIDTH-1:0] o_best_code,
    output logic [ADC_WIDTH-1:0] o_best_pwr
);

    localparam int CW = $clog2(SettleCycles + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SettleCycles);

    tuner_sweep_state_e   r_state, w_next;
    logic [DAC_WIDTH-1:0] r_cur, r_end, r_step, r_dac;
    logic                 r_mode;
    logic [ADC_WIDTH-1:0] r_sample;
    logic [CW-1:0]        r_cnt;

    logic                 w_clear, w_update, w_more;
    logic [DAC_WIDTH:0]   w_sum;
    logic                 w_trk_mode;
    logic [DAC_WIDTH-1:0] w_trk_code, w_nxt_code;

    // One extra bit catches wrap-around past the top code.
    assign w_sum  = {1'b0, r_cur} + {1'b0, r_step};
    assign w_more = (r_step != '0) && !w_sum[DAC_WIDTH]
                 && (w_sum[DAC_WIDTH-1:0] <= r_end);

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_update = 1'b0;
        if (r_state != ST_IDLE && i_sweep_abort) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_sweep_start) begin
                        w_next  = ST_SET;
                        w_clear = 1'b1;
                    end
                end
                ST_SET:    w_next = ST_SETTLE;
                ST_SETTLE: if (r_cnt == CW'(1)) w_next = ST_REQ;
                ST_REQ:    if (i_pwr_read_rdy) w_next = ST_WAIT;
                ST_WAIT:   if (i_pwr_detect_val) w_next = ST_UPDATE;
                ST_UPDATE: begin
                    w_update = 1'b1;
                    w_next   = w_more ? ST_SET : ST_DONE;
                end
                ST_DONE:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cur    <= '0;
            r_end    <= '0;
            r_step   <= '0;
            r_dac    <= '0;
            r_mode   <= 1'b0;
            r_sample <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_mode <= i_sweep_mode;
                r_cur  <= i_code_start;
                r_end  <= i_code_end;
                r_step <= i_code_step;
            end
            if (r_state == ST_SET && w_next == ST_SETTLE) begin
                r_dac <= r_cur;
                r_cnt <= SETTLE_LOAD;
            end
            if (r_state == ST_SETTLE)
                r_cnt <= r_cnt - CW'(1);
            if (r_state == ST_WAIT && w_next == ST_UPDATE)
                r_sample <= i_pwr_detect_data;
            if (r_state == ST_UPDATE && w_next == ST_SET)
                r_cur <= w_sum[DAC_WIDTH-1:0];
            // Park on the best code including the final point's result.
            if (r_state == ST_UPDATE && w_next == ST_DONE)
                r_dac <= w_nxt_code;
        end
    end

    // Clear uses the live start inputs since the latches load the same edge.
    assign w_trk_mode = w_clear ? i_sweep_mode : r_mode;
    assign w_trk_code = w_clear ? i_code_start : r_cur;

    tuner_sweep_best_tracker #(
        .DAC_WIDTH(DAC_WIDTH),
        .ADC_WIDTH(ADC_WIDTH)
    ) u_best (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_mode     (w_trk_mode),
        .i_sample   (r_sample),
        .i_code     (w_trk_code),
        .i_update   (w_update),
        .i_clear    (w_clear),
        .o_best_code(o_best_code),
        .o_nxt_code (w_nxt_code),
        .o_best_pwr (o_best_pwr)
    );

    assign o_dac_tune       = r_dac;
    assign o_pwr_read_val   = (r_state == ST_REQ);
    assign o_pwr_detect_rdy = (r_state == ST_WAIT);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = (r_state == ST_DONE);

endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// Self-checking bench for tuner_sweep_ctrl: directed vectors, random
// sweeps against a behavioural model, abort and mid-sweep reset.
module tb_tuner_sweep_ctrl;

    localparam int SETTLE = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_sweep_start, i_sweep_abort, i_sweep_mode;
    logic [7:0] i_code_start, i_code_end, i_code_step;
    logic [7:0] o_dac_tune;
    logic       o_pwr_read_val, i_pwr_read_rdy;
    logic       i_pwr_detect_val, o_pwr_detect_rdy;
    logic [7:0] i_pwr_detect_data;
    logic       o_busy, o_done;
    logic [7:0] o_best_code, o_best_pwr;

    tuner_sweep_ctrl #(
        .DAC_WIDTH(8),
        .ADC_WIDTH(8),
        .SettleCycles(SETTLE)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_sweep_start    (i_sweep_start),
        .i_sweep_abort    (i_sweep_abort),
        .i_sweep_mode     (i_sweep_mode),
        .i_code_start     (i_code_start),
        .i_code_end       (i_code_end),
        .i_code_step      (i_code_step),
        .o_dac_tune       (o_dac_tune),
        .o_pwr_read_val   (o_pwr_read_val),
        .i_pwr_read_rdy   (i_pwr_read_rdy),
        .i_pwr_detect_val (i_pwr_detect_val),
        .o_pwr_detect_rdy (o_pwr_detect_rdy),
        .i_pwr_detect_data(i_pwr_detect_data),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_best_code      (o_best_code),
        .o_best_pwr       (o_best_pwr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic m;
        int   s, e, st;
        int   n, bc, bp;
        int   smp[8];
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int g_smp[256];
    int g_code[256];

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    endtask

    // Reference: walk the code list with plain integers, strict best.
    task automatic model(input bit m, input int s, input int e,
                         input int st, output int n, output int bc,
                         output int bp);
        int c;
        c  = s;
        n  = 0;
        bp = m ? 0 : 255;
        bc = s;
        while (1) begin
            g_code[n] = c;
            if (m ? (g_smp[n] > bp) : (g_smp[n] < bp)) begin
                bp = g_smp[n];
                bc = c;
            end
            n++;
            if (st == 0 || c + st > e) break;
            c = c + st;
        end
    endtask

    task automatic start_sweep(input bit m, input int s, input int e,
                               input int st);
        i_sweep_mode  = m;
        i_code_start  = 8'(s);
        i_code_end    = 8'(e);
        i_code_step   = 8'(st);
        i_sweep_start = 1'b1;
        @(posedge i_clk); #1;
        i_sweep_start = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input bit m, input int s,
                             input int e, input int st, input int exp_n,
                             input int exp_bc, input int exp_bp,
                             input bit rnd);
        int pt, dones, cyc, post, mn, mbc, mbp;
        model(m, s, e, st, mn, mbc, mbp);
        start_sweep(m, s, e, st);
        pt = 0; dones = 0; cyc = 0; post = 0;
        while (cyc < 4000 && post < 3) begin
            i_pwr_read_rdy    = rnd ? 1'($urandom % 2) : 1'b1;
            i_pwr_detect_val  = rnd ? 1'($urandom % 2) : 1'b1;
            i_pwr_detect_data = 8'(g_smp[pt & 255]);
            i_sweep_start     = (rnd && o_busy) ? 1'($urandom % 2) : 1'b0;
            if (o_pwr_read_val && i_pwr_read_rdy)
                check({tag, " point code"}, int'(o_dac_tune),
                      g_code[pt & 255]);
            if (o_pwr_detect_rdy && i_pwr_detect_val) pt++;
            if (o_done) begin
                dones++;
                check({tag, " best_code"}, int'(o_best_code), exp_bc);
                check({tag, " best_pwr"}, int'(o_best_pwr), exp_bp);
                check({tag, " dac at done"}, int'(o_dac_tune), exp_bc);
                if (!rnd)
                    check({tag, " sweep latency"}, cyc,
                          exp_n * (SETTLE + 4));
            end
            if (dones > 0 && !o_done) post++;
            @(posedge i_clk); #1;
            cyc++;
        end
        i_sweep_start    = 1'b0;
        i_pwr_read_rdy   = 1'b0;
        i_pwr_detect_val = 1'b0;
        check({tag, " finished in budget"}, int'(cyc < 4000), 1);
        check({tag, " points"}, pt, exp_n);
        check({tag, " done pulses"}, dones, 1);
        check({tag, " idle after"}, int'(o_busy), 0);
    endtask

    vec_t vecs[5];

    function automatic vec_t mk(bit m, int s, int e, int st, int n,
                                int bc, int bp, int a0, int a1 = 0,
                                int a2 = 0, int a3 = 0, int a4 = 0);
        vec_t v;
        v.m = m; v.s = s; v.e = e; v.st = st;
        v.n = n; v.bc = bc; v.bp = bp;
        foreach (v.smp[i]) v.smp[i] = 0;
        v.smp[0] = a0; v.smp[1] = a1; v.smp[2] = a2;
        v.smp[3] = a3; v.smp[4] = a4;
        return v;
    endfunction

    task automatic load_vec(input int k);
        foreach (g_smp[i]) g_smp[i] = 0;
        for (int i = 0; i < 8; i++) g_smp[i] = vecs[k].smp[i];
    endtask

    initial begin
        int m, s, e, st, n, bc, bp, hi;

        vecs[0] = mk(0, 0, 8, 2, 5, 4, 10, 50, 30, 10, 20, 40);
        vecs[1] = mk(1, 0, 3, 1, 4, 1, 9, 5, 9, 9, 3);
        vecs[2] = mk(0, 250, 255, 4, 2, 254, 20, 60, 20);
        vecs[3] = mk(0, 10, 5, 1, 1, 10, 77, 77);
        vecs[4] = mk(0, 10, 200, 0, 1, 10, 88, 88);

        i_rst_n = 1'b0;
        i_sweep_start = 0; i_sweep_abort = 0; i_sweep_mode = 0;
        i_code_start = 0; i_code_end = 0; i_code_step = 0;
        i_pwr_read_rdy = 0; i_pwr_detect_val = 0; i_pwr_detect_data = 0;
        #12;
        check("reset busy", int'(o_busy), 0);
        check("reset dac", int'(o_dac_tune), 0);
        check("reset read_val", int'(o_pwr_read_val), 0);
        check("reset detect_rdy", int'(o_pwr_detect_rdy), 0);
        check("reset best_code", int'(o_best_code), 0);
        check("reset best_pwr", int'(o_best_pwr), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // First-request latency: SET plus SettleCycles.
        load_vec(0);
        start_sweep(0, 0, 8, 2);
        i_pwr_read_rdy = 1'b0;
        n = 0;
        while (!o_pwr_read_val && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("first request latency", n, SETTLE + 1);
        i_sweep_abort = 1'b1;
        @(posedge i_clk); #1;
        i_sweep_abort = 1'b0;
        @(posedge i_clk); #1;

        for (int k = 0; k < 5; k++) begin
            load_vec(k);
            run_sweep($sformatf("vec%0d", k), vecs[k].m, vecs[k].s,
                      vecs[k].e, vecs[k].st, vecs[k].n, vecs[k].bc,
                      vecs[k].bp, 1'b0);
            run_sweep($sformatf("vec%0d stall", k), vecs[k].m,
                      vecs[k].s, vecs[k].e, vecs[k].st, vecs[k].n,
                      vecs[k].bc, vecs[k].bp, 1'b1);
        end

        for (int r = 0; r < 20; r++) begin
            m  = int'($urandom % 2);
            s  = int'($urandom % 256);
            e  = int'($urandom % 256);
            st = ($urandom_range(0, 5) == 0) ? 0
                 : int'($urandom_range(16, 80));
            hi = ($urandom % 2) ? 255 : 7;
            foreach (g_smp[i]) g_smp[i] = int'($urandom_range(0, hi));
            model(m[0], s, e, st, n, bc, bp);
            run_sweep($sformatf("rand%0d", r), m[0], s, e, st, n, bc, bp,
                      1'b1);
        end

        // Abort while the power read request is stalled.
        start_sweep(0, 6, 20, 2);
        i_pwr_read_rdy = 1'b0;
        n = 0;
        while (!o_pwr_read_val && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(o_pwr_read_val);
            @(posedge i_clk); #1;
        end
        check("abort read_val held", hi, 20);
        i_sweep_abort = 1'b1;
        i_pwr_read_rdy = 1'b1;
        @(posedge i_clk); #1;
        i_sweep_abort = 1'b0;
        i_pwr_read_rdy = 1'b0;
        check("abort busy", int'(o_busy), 0);
        check("abort read_val", int'(o_pwr_read_val), 0);
        check("abort dac kept", int'(o_dac_tune), 6);
        check("abort best_code kept", int'(o_best_code), 6);
        check("abort best_pwr kept", int'(o_best_pwr), 255);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            hi += int'(o_done) + int'(o_busy);
            @(posedge i_clk); #1;
        end
        check("abort no done", hi, 0);

        // Reset during SETTLE of the third point.
        load_vec(0);
        start_sweep(0, 0, 8, 2);
        i_pwr_read_rdy = 1'b1;
        i_pwr_detect_val = 1'b1;
        for (int i = 0; i < 18; i++) begin
            i_pwr_detect_data = 8'(g_smp[i / (SETTLE + 4)]);
            @(posedge i_clk); #1;
        end
        check("pre-reset dac", int'(o_dac_tune), 4);
        #1 i_rst_n = 1'b0;
        #1;
        check("async rst dac", int'(o_dac_tune), 0);
        check("async rst busy", int'(o_busy), 0);
        check("async rst best_code", int'(o_best_code), 0);
        check("async rst best_pwr", int'(o_best_pwr), 0);
        check("async rst read_val", int'(o_pwr_read_val), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            hi += int'(o_pwr_detect_rdy) + int'(o_busy);
            @(posedge i_clk); #1;
        end
        check("post-reset quiet", hi, 0);
        i_pwr_read_rdy = 1'b0;
        i_pwr_detect_val = 1'b0;
        run_sweep("after reset", 0, 0, 8, 2, 5, 4, 10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
